dma_req_arbiter: RTL and testbench



---
 rtl/dma_req_arbiter.sv | 143 ++++++++++++++
 tb/tb_dma_req_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dma_req_arbiter.sv
// rtl/dma_req_arbiter.sv - round-robin merge of per-stream DMA requests with outstanding-count throttling
module dma_req_arbiter #(
    parameter int N_SCHAN       = 2,
    parameter int VADDR_BITS    = 48,
    parameter int LEN_BITS      = 28,
    parameter int N_OUTSTANDING = 8,
    localparam int IDW          = (N_SCHAN > 1) ? $clog2(N_SCHAN) : 1
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [N_SCHAN-1:0]           s_req_valid,
    output logic [N_SCHAN-1:0]           s_req_ready,
    input  logic [N_SCHAN*VADDR_BITS-1:0] s_req_vaddr,
    input  logic [N_SCHAN*LEN_BITS-1:0]  s_req_len,
    input  logic [N_SCHAN-1:0]           s_req_last,
    output logic                         m_req_valid,
    input  logic                         m_req_ready,
    output logic [VADDR_BITS-1:0]        m_req_vaddr,
    output logic [LEN_BITS-1:0]          m_req_len,
    output logic                         m_req_last,
    output logic [IDW-1:0]               m_req_id,
    input  logic                         s_cmpl_valid,
    input  logic [IDW-1:0]               s_cmpl_id,
    output logic                         cmpl_err
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [IDW-1:0]          rr_q, rr_d;
    logic [7:0]              cnt_q [N_SCHAN];
    logic [7:0]              cnt_d [N_SCHAN];
    logic [VADDR_BITS-1:0]   vaddr_q, vaddr_d;
    logic [LEN_BITS-1:0]     len_q, len_d;
    logic                    last_q, last_d;
    logic [IDW-1:0]          id_q, id_d;
    logic                    err_q, err_d;

    logic [N_SCHAN-1:0]      elig;
    logic [N_SCHAN-1:0]      cmpl_hit;
    logic                    cmpl_ok;
    logic                    slot_open;
    logic                    gnt_found;
    logic [IDW-1:0]          gnt_idx;
    int unsigned             scan_idx;

    always_comb begin
        slot_open = (state_q == IDLE) || m_req_ready;
        for (int i = 0; i < N_SCHAN; i++) begin
            elig[i]     = s_req_valid[i] && (cnt_q[i] < 8'(N_OUTSTANDING));
            cmpl_hit[i] = s_cmpl_valid && (s_cmpl_id == IDW'(i));
        end
        // A completion is only honoured against a non-zero counter of an existing stream
        cmpl_ok = 1'b0;
        for (int i = 0; i < N_SCHAN; i++) begin
            if (cmpl_hit[i] && (cnt_q[i] != 8'd0)) begin
                cmpl_ok = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = 0;
        for (int k = 0; k < N_SCHAN; k++) begin
            scan_idx = (int'(rr_q) + k) % N_SCHAN;
            if (!gnt_found && elig[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(scan_idx);
            end
        end
        if (areset || !slot_open) begin
            gnt_found = 1'b0;
        end
        s_req_ready = '0;
        if (gnt_found) begin
            s_req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        vaddr_d = vaddr_q;
        len_d   = len_q;
        last_d  = last_q;
        id_d    = id_q;
        err_d   = err_q || (s_cmpl_valid && !cmpl_ok);
        for (int i = 0; i < N_SCHAN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s_req_ready[i] && !(cmpl_hit[i] && cmpl_ok)) begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end else if (!s_req_ready[i] && cmpl_hit[i] && cmpl_ok) begin
                cnt_d[i] = cnt_q[i] - 8'd1;
            end
        end
        if (gnt_found) begin
            state_d = BUSY;
            vaddr_d = s_req_vaddr[gnt_idx*VADDR_BITS +: VADDR_BITS];
            len_d   = s_req_len[gnt_idx*LEN_BITS +: LEN_BITS];
            last_d  = s_req_last[gnt_idx];
            id_d    = gnt_idx;
            rr_d    = IDW'((int'(gnt_idx) + 1) % N_SCHAN);
        end else if (slot_open) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            vaddr_q <= '0;
            len_q   <= '0;
            last_q  <= 1'b0;
            id_q    <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < N_SCHAN; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            vaddr_q <= vaddr_d;
            len_q   <= len_d;
            last_q  <= last_d;
            id_q    <= id_d;
            err_q   <= err_d;
            for (int i = 0; i < N_SCHAN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign m_req_valid = (state_q == BUSY);
    assign m_req_vaddr = vaddr_q;
    assign m_req_len   = len_q;
    assign m_req_last  = last_q;
    assign m_req_id    = id_q;
    assign cmpl_err    = err_q;

endmodule

// File: tb/tb_dma_req_arbiter.sv
// tb/tb_dma_req_arbiter.sv - randomized and directed checks of dma_req_arbiter against a request-level model
module tb_dma_req_arbiter;
    localparam int N   = 2;
    localparam int VB  = 48;
    localparam int LB  = 28;
    localparam int NO  = 2;
    localparam int IDW = 1;

    logic            aclk = 1'b0;
    logic            areset;
    logic [N-1:0]    s_req_valid, s_req_ready, s_req_last;
    logic [N*VB-1:0] s_req_vaddr;
    logic [N*LB-1:0] s_req_len;
    logic            m_req_valid, m_req_ready, m_req_last;
    logic [VB-1:0]   m_req_vaddr;
    logic [LB-1:0]   m_req_len;
    logic [IDW-1:0]  m_req_id;
    logic            s_cmpl_valid;
    logic [IDW-1:0]  s_cmpl_id;
    logic            cmpl_err;

    dma_req_arbiter #(.N_SCHAN(N), .VADDR_BITS(VB), .LEN_BITS(LB), .N_OUTSTANDING(NO)) dut (
        .aclk(aclk), .areset(areset),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_req_vaddr(s_req_vaddr), .s_req_len(s_req_len), .s_req_last(s_req_last),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_req_vaddr(m_req_vaddr), .m_req_len(m_req_len), .m_req_last(m_req_last),
        .m_req_id(m_req_id),
        .s_cmpl_valid(s_cmpl_valid), .s_cmpl_id(s_cmpl_id), .cmpl_err(cmpl_err)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Request-level model: one held request slot, per-stream outstanding counts, fairness pointer
    bit            md_hold;
    logic [VB-1:0] md_vaddr;
    logic [LB-1:0] md_len;
    bit            md_last;
    int            md_id;
    int            md_rr;
    int            md_out [N];
    bit            md_err;

    bit            hold_data = 0;
    logic [N-1:0]  obs_rdy;
    int            handshakes;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        md_hold = 0; md_vaddr = '0; md_len = '0; md_last = 0; md_id = 0; md_rr = 0; md_err = 0;
        for (int i = 0; i < N; i++) md_out[i] = 0;
    endtask

    task automatic step(input bit rst, input logic [N-1:0] v, input bit mr, input bit cv, input int cid);
        int  g;
        bit  open;
        bit  cok;
        logic [N-1:0] exp_rdy;
        areset = rst; s_req_valid = v; m_req_ready = mr; s_cmpl_valid = cv;
        s_cmpl_id = cid[IDW-1:0];
        if (!hold_data) begin
            for (int i = 0; i < N; i++) begin
                s_req_vaddr[i*VB +: VB] = {$urandom, $urandom};
                s_req_len[i*LB +: LB]   = LB'($urandom);
                s_req_last[i]           = $urandom_range(0, 1);
            end
        end
        #1;
        open = !md_hold || mr;
        g = -1;
        if (!rst && open) begin
            for (int k = 0; k < N; k++) begin
                int i = (md_rr + k) % N;
                if (g < 0 && v[i] && md_out[i] < NO) g = i;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        obs_rdy = s_req_ready;
        check_eq("s_req_ready", s_req_ready, exp_rdy);
        check_eq("m_req_valid", m_req_valid, md_hold);
        if (md_hold) begin
            check_eq("m_req_vaddr", m_req_vaddr, md_vaddr);
            check_eq("m_req_len", m_req_len, md_len);
            check_eq("m_req_last", m_req_last, md_last);
            check_eq("m_req_id", m_req_id, md_id);
        end
        check_eq("cmpl_err", cmpl_err, md_err);
        if (md_hold && mr && !rst) handshakes++;
        if (rst) begin
            model_reset();
        end else begin
            cok = cv && cid < N && md_out[cid] > 0;
            if (cv && !cok) md_err = 1;
            if (cok) md_out[cid]--;
            if (g >= 0) begin
                md_out[g]++;
                md_hold  = 1;
                md_vaddr = s_req_vaddr[g*VB +: VB];
                md_len   = s_req_len[g*LB +: LB];
                md_last  = s_req_last[g];
                md_id    = g;
                md_rr    = (g + 1) % N;
            end else if (open) begin
                md_hold = 0;
            end
        end
        @(posedge aclk);
        @(negedge aclk);
    endtask

    initial begin
        logic [N-1:0] rv;
        int           cid;
        areset = 1; s_req_valid = '0; m_req_ready = 0; s_cmpl_valid = 0; s_cmpl_id = '0;
        s_req_vaddr = '0; s_req_len = '0; s_req_last = '0;
        model_reset();
        @(posedge aclk);
        @(negedge aclk);
        step(1, 2'b11, 1, 0, 0);
        check_eq("rst_ready", obs_rdy, 2'b00);
        check_eq("rst_valid", m_req_valid, 0);

        // Both streams always valid: strict alternation without bubbles
        step(0, 2'b11, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            check_eq("rr_valid", m_req_valid, 1);
            check_eq("rr_seq", m_req_id, k % 2);
            step(0, 2'b11, 1, 1, md_id);
        end

        // Stall with a held request: outputs frozen, single handshake
        step(1, 2'b00, 0, 0, 0);
        hold_data = 1;
        s_req_vaddr[0 +: VB] = 48'h1000;
        s_req_len[0 +: LB]   = 28'd64;
        s_req_last[0]        = 1'b1;
        handshakes = 0;
        step(0, 2'b01, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            check_eq("stall_vaddr", m_req_vaddr, 48'h1000);
            check_eq("stall_len", m_req_len, 64);
            step(0, 2'b01, 0, 0, 0);
            check_eq("stall_ready", obs_rdy, 2'b00);
        end
        step(0, 2'b00, 1, 0, 0);
        step(0, 2'b00, 1, 0, 0);
        check_eq("stall_handshakes", handshakes, 1);
        hold_data = 0;

        // Outstanding limit on stream 1, released one cycle after a completion
        step(1, 2'b00, 0, 0, 0);
        step(0, 2'b10, 1, 0, 0);
        check_eq("lim_g1", obs_rdy, 2'b10);
        step(0, 2'b10, 1, 0, 0);
        check_eq("lim_g2", obs_rdy, 2'b10);
        step(0, 2'b10, 1, 0, 0);
        check_eq("lim_block", obs_rdy, 2'b00);
        step(0, 2'b10, 1, 1, 1);
        check_eq("lim_same_cycle", obs_rdy, 2'b00);
        step(0, 2'b10, 1, 0, 0);
        check_eq("lim_release", obs_rdy, 2'b10);

        // Grant and completion to stream 0 in one cycle keep its count at 1
        step(1, 2'b00, 0, 0, 0);
        step(0, 2'b01, 1, 0, 0);
        step(0, 2'b01, 1, 1, 0);
        check_eq("gc_grant", obs_rdy, 2'b01);
        step(0, 2'b01, 1, 0, 0);
        check_eq("gc_second", obs_rdy, 2'b01);
        step(0, 2'b01, 1, 0, 0);
        check_eq("gc_full", obs_rdy, 2'b00);
        check_eq("gc_err", cmpl_err, 0);

        // Completion on an idle stream is a sticky error
        step(1, 2'b00, 0, 0, 0);
        step(0, 2'b00, 1, 1, 1);
        for (int k = 0; k < 3; k++) begin
            check_eq("err_sticky", cmpl_err, 1);
            step(0, 2'b11, 1, 0, 0);
        end
        step(1, 2'b00, 0, 0, 0);
        check_eq("err_cleared", cmpl_err, 0);

        // Reset while busy drops the held request and restarts arbitration at stream 0
        step(0, 2'b11, 1, 0, 0);
        step(0, 2'b11, 0, 0, 0);
        step(1, 2'b11, 0, 0, 0);
        check_eq("rstb_valid", m_req_valid, 0);
        step(0, 2'b11, 1, 0, 0);
        check_eq("rstb_first", obs_rdy, 2'b01);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rv  = N'($urandom);
            cid = $urandom_range(0, N - 1);
            if ($urandom_range(0, 9) != 0 && md_out[cid] == 0) cid = (cid + 1) % N;
            step($urandom_range(0, 99) == 0, rv, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0, cid);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
